// File: rtl/reg_scoreboard.sv
// Register scoreboard: 2-bit pending-write counters for x1..x31, issue stall, writeback bypass.
// Optional macro SCOREBOARD_FWD_EN: a source whose last pending write retires this cycle is bypassed instead of stalled.
module reg_scoreboard (
  input  logic        CLK,
  input  logic        RST,
  input  logic        FLUSH,
  input  logic        ISSUE_VALID,
  input  logic [4:0]  ISSUE_RS1,
  input  logic [4:0]  ISSUE_RS2,
  input  logic [4:0]  ISSUE_RD,
  output logic        STALL,
  input  logic        WB_VALID,
  input  logic [4:0]  WB_RD,
  input  logic [31:0] WB_DATA,
  input  logic [4:0]  REG_IR_O_A,
  input  logic [4:0]  REG_IR_O_B,
  input  logic [31:0] REG_IR_O_AV,
  input  logic [31:0] REG_IR_O_BV,
  output logic [31:0] FWD_AV,
  output logic [31:0] FWD_BV,
  output logic        ERR
);

  logic [31:0][1:0] cnt;
  logic [31:0]      busy;
  logic [31:0]      retire;
  logic             haz1, haz2, rd_full, accept;

  // cnt[0] is only ever cleared, so busy[0]/retire[0] stay low and x0 never hazards
  always_comb begin
    busy   = '0;
    retire = '0;
    for (int r = 0; r < 32; r++) begin
      busy[r]   = cnt[r] != 2'd0;
      retire[r] = WB_VALID && (WB_RD == 5'(r)) && busy[r];
    end
  end

`ifdef SCOREBOARD_FWD_EN
  assign haz1 = busy[ISSUE_RS1] && !(cnt[ISSUE_RS1] == 2'd1 && retire[ISSUE_RS1]);
  assign haz2 = busy[ISSUE_RS2] && !(cnt[ISSUE_RS2] == 2'd1 && retire[ISSUE_RS2]);
`else
  assign haz1 = busy[ISSUE_RS1];
  assign haz2 = busy[ISSUE_RS2];
`endif

  assign rd_full = (cnt[ISSUE_RD] == 2'd3) && !retire[ISSUE_RD];
  assign STALL   = !RST && ISSUE_VALID && (haz1 || haz2 || rd_full);
  assign accept  = ISSUE_VALID && !STALL;

  assign FWD_AV = (REG_IR_O_A == 5'd0) ? 32'd0 :
                  (WB_VALID && WB_RD == REG_IR_O_A) ? WB_DATA : REG_IR_O_AV;
  assign FWD_BV = (REG_IR_O_B == 5'd0) ? 32'd0 :
                  (WB_VALID && WB_RD == REG_IR_O_B) ? WB_DATA : REG_IR_O_BV;

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt <= '0;
      ERR <= 1'b0;
    end else if (FLUSH) begin
      cnt <= '0;
    end else begin
      for (int r = 1; r < 32; r++) begin
        case ({accept && (ISSUE_RD == 5'(r)), retire[r]})
          2'b10:   cnt[r] <= cnt[r] + 2'd1;
          2'b01:   cnt[r] <= cnt[r] - 2'd1;
          default: cnt[r] <= cnt[r];
        endcase
      end
      // writeback to a register with nothing pending is dropped but flagged
      if (WB_VALID && WB_RD != 5'd0 && !busy[WB_RD])
        ERR <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed scenarios plus random traffic against a counter-array model.
module tb_reg_scoreboard;
  logic        CLK = 1'b0;
  logic        RST, FLUSH, ISSUE_VALID, WB_VALID;
  logic [4:0]  ISSUE_RS1, ISSUE_RS2, ISSUE_RD, WB_RD, REG_IR_O_A, REG_IR_O_B;
  logic [31:0] WB_DATA, REG_IR_O_AV, REG_IR_O_BV;
  logic        STALL, ERR;
  logic [31:0] FWD_AV, FWD_BV;

  int checks = 0;
  int errors = 0;
  int mcnt[32];
  bit merr;

  reg_scoreboard dut (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .ISSUE_VALID(ISSUE_VALID),
    .ISSUE_RS1(ISSUE_RS1), .ISSUE_RS2(ISSUE_RS2), .ISSUE_RD(ISSUE_RD), .STALL(STALL),
    .WB_VALID(WB_VALID), .WB_RD(WB_RD), .WB_DATA(WB_DATA),
    .REG_IR_O_A(REG_IR_O_A), .REG_IR_O_B(REG_IR_O_B),
    .REG_IR_O_AV(REG_IR_O_AV), .REG_IR_O_BV(REG_IR_O_BV),
    .FWD_AV(FWD_AV), .FWD_BV(FWD_BV), .ERR(ERR));

  always #5 CLK = ~CLK;

`ifdef SCOREBOARD_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  // ---- reference model ----
  function automatic bit m_ret(int r);
    return WB_VALID && int'(WB_RD) == r && r != 0 && mcnt[r] != 0;
  endfunction

  function automatic bit m_haz(int rs);
    if (rs == 0 || mcnt[rs] == 0) return 0;
    if (FWD_EN && mcnt[rs] == 1 && m_ret(rs)) return 0;
    return 1;
  endfunction

  function automatic bit m_stall();
    if (RST || !ISSUE_VALID) return 0;
    return m_haz(ISSUE_RS1) || m_haz(ISSUE_RS2) ||
           (mcnt[ISSUE_RD] == 3 && !m_ret(ISSUE_RD));
  endfunction

  function automatic logic [31:0] m_fwd(logic [4:0] idx, logic [31:0] v);
    if (idx == 0) return 32'd0;
    if (WB_VALID && WB_RD == idx) return WB_DATA;
    return v;
  endfunction

  function automatic void m_clock();
    int nxt[32];
    bit acc;
    acc = ISSUE_VALID && !m_stall();
    if (RST) begin
      foreach (mcnt[i]) mcnt[i] = 0;
      merr = 0;
    end else if (FLUSH) begin
      foreach (mcnt[i]) mcnt[i] = 0;
    end else begin
      if (WB_VALID && WB_RD != 0 && mcnt[WB_RD] == 0) merr = 1;
      foreach (mcnt[i]) nxt[i] = mcnt[i];
      for (int r = 1; r < 32; r++) begin
        if (acc && int'(ISSUE_RD) == r) nxt[r] = nxt[r] + 1;
        if (m_ret(r)) nxt[r] = nxt[r] - 1;
      end
      foreach (mcnt[i]) mcnt[i] = nxt[i];
    end
  endfunction

  // ---- stimulus helpers (no comparisons) ----
  task automatic idle();
    RST = 0; FLUSH = 0; ISSUE_VALID = 0; ISSUE_RS1 = 0; ISSUE_RS2 = 0; ISSUE_RD = 0;
    WB_VALID = 0; WB_RD = 0; WB_DATA = 0;
    REG_IR_O_A = 0; REG_IR_O_B = 0; REG_IR_O_AV = 0; REG_IR_O_BV = 0;
  endtask

  task automatic tick();
    @(posedge CLK);
    m_clock();
    @(negedge CLK);
  endtask

  task automatic do_reset();
    idle(); RST = 1; tick(); RST = 0;
  endtask

  task automatic issue(logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd);
    ISSUE_VALID = 1; ISSUE_RS1 = rs1; ISSUE_RS2 = rs2; ISSUE_RD = rd;
  endtask

  // ---- tests ----
  task automatic test_reset();
    idle();
    RST = 1; FLUSH = 1; issue(5'd1, 5'd2, 5'd3); WB_VALID = 1; WB_RD = 5'd9;
    WB_DATA = 32'hA5A5_0001; REG_IR_O_A = 5'd9; REG_IR_O_AV = 32'h1234;
    #1;
    checks++;
    if (STALL !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", STALL); end
    checks++;
    if (FWD_AV !== 32'hA5A5_0001) begin errors++; $display("FAIL reset_fwd got %h want a5a50001", FWD_AV); end
    tick();
    idle(); #1;
    checks++;
    if (ERR !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", ERR); end
    issue(5'd1, 5'd2, 5'd3); #1;
    checks++;
    if (STALL !== 1'b0) begin errors++; $display("FAIL reset_counts_clear got %b want 0", STALL); end
    idle();
  endtask

  task automatic test_raw();
    do_reset();
    issue(5'd0, 5'd0, 5'd5); tick();
    issue(5'd5, 5'd0, 5'd0); #1;
    checks++;
    if (STALL !== 1'b1) begin errors++; $display("FAIL raw_stall got %b want 1", STALL); end
    idle(); WB_VALID = 1; WB_RD = 5'd5; WB_DATA = 32'h55; tick();
    idle(); issue(5'd5, 5'd0, 5'd0); #1;
    checks++;
    if (STALL !== m_stall() || STALL !== 1'b0) begin errors++; $display("FAIL raw_release got %b want 0", STALL); end
    tick(); idle();
  endtask

  task automatic test_fwd_hazard();
    logic want;
    do_reset();
    issue(5'd0, 5'd0, 5'd7); tick();
    issue(5'd0, 5'd7, 5'd0); WB_VALID = 1; WB_RD = 5'd7; WB_DATA = 32'hDEADBEEF;
    REG_IR_O_B = 5'd7; REG_IR_O_BV = 32'h0BAD_0BAD; #1;
    want = !FWD_EN;
    checks++;
    if (STALL !== want) begin errors++; $display("FAIL fwd_hazard_stall got %b want %b", STALL, want); end
    checks++;
    if (FWD_BV !== 32'hDEADBEEF) begin errors++; $display("FAIL fwd_hazard_bv got %h want deadbeef", FWD_BV); end
    tick();
    WB_VALID = 0; WB_RD = 0; #1;
    checks++;
    if (STALL !== 1'b0) begin errors++; $display("FAIL fwd_hazard_next got %b want 0", STALL); end
    tick(); idle();
  endtask

  task automatic test_saturate();
    do_reset();
    repeat (3) begin issue(5'd0, 5'd0, 5'd3); tick(); end
    issue(5'd0, 5'd0, 5'd3); #1;
    checks++;
    if (STALL !== 1'b1) begin errors++; $display("FAIL sat_full got %b want 1", STALL); end
    WB_VALID = 1; WB_RD = 5'd3; WB_DATA = 32'h3; #1;
    checks++;
    if (STALL !== 1'b0) begin errors++; $display("FAIL sat_retire got %b want 0", STALL); end
    tick();
    WB_VALID = 0; WB_RD = 0; #1;
    checks++;
    if (STALL !== 1'b1 || mcnt[3] != 3) begin errors++; $display("FAIL sat_hold got %b want 1 (model cnt %0d)", STALL, mcnt[3]); end
    idle();
  endtask

  task automatic test_bypass();
    do_reset();
    REG_IR_O_A = 5'd9; REG_IR_O_AV = 32'h11; WB_VALID = 1; WB_RD = 5'd9; WB_DATA = 32'h22; #1;
    checks++;
    if (FWD_AV !== 32'h22) begin errors++; $display("FAIL bypass_a got %h want 22", FWD_AV); end
    WB_RD = 5'd10; #1;
    checks++;
    if (FWD_AV !== 32'h11) begin errors++; $display("FAIL bypass_nomatch got %h want 11", FWD_AV); end
    REG_IR_O_A = 5'd0; REG_IR_O_AV = 32'h55; WB_RD = 5'd0; WB_DATA = 32'h77; #1;
    checks++;
    if (FWD_AV !== 32'h0) begin errors++; $display("FAIL bypass_x0 got %h want 0", FWD_AV); end
    idle();
  endtask

  task automatic test_err();
    do_reset();
    WB_VALID = 1; WB_RD = 5'd0; tick();
    WB_VALID = 0; #1;
    checks++;
    if (ERR !== 1'b0) begin errors++; $display("FAIL err_x0 got %b want 0", ERR); end
    WB_VALID = 1; WB_RD = 5'd12; WB_DATA = 32'h12; tick();
    idle(); #1;
    checks++;
    if (ERR !== 1'b1) begin errors++; $display("FAIL err_set got %b want 1", ERR); end
    FLUSH = 1; tick(); FLUSH = 0; tick(); #1;
    checks++;
    if (ERR !== 1'b1) begin errors++; $display("FAIL err_flush_hold got %b want 1", ERR); end
    do_reset(); #1;
    checks++;
    if (ERR !== 1'b0) begin errors++; $display("FAIL err_rst_clear got %b want 0", ERR); end
  endtask

  task automatic test_flush();
    do_reset();
    issue(5'd0, 5'd0, 5'd4); tick();
    issue(5'd0, 5'd0, 5'd6); tick();
    issue(5'd0, 5'd0, 5'd4); FLUSH = 1; #1;
    checks++;
    if (STALL !== 1'b0) begin errors++; $display("FAIL flush_accept got %b want 0", STALL); end
    tick(); FLUSH = 0;
    issue(5'd4, 5'd6, 5'd0); #1;
    checks++;
    if (STALL !== 1'b0) begin errors++; $display("FAIL flush_clear got %b want 0", STALL); end
    idle();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      RST   = ($urandom_range(0, 99) == 0);
      FLUSH = ($urandom_range(0, 39) == 0);
      ISSUE_VALID = ($urandom_range(0, 3) != 0);
      ISSUE_RS1 = 5'($urandom_range(0, 6));
      ISSUE_RS2 = 5'($urandom_range(0, 6));
      ISSUE_RD  = 5'($urandom_range(0, 6));
      WB_VALID  = ($urandom_range(0, 2) != 0);
      WB_RD     = 5'($urandom_range(0, 6));
      WB_DATA   = $urandom;
      REG_IR_O_A = 5'($urandom_range(0, 6));
      REG_IR_O_B = 5'($urandom_range(0, 6));
      REG_IR_O_AV = $urandom;
      REG_IR_O_BV = $urandom;
      #1;
      checks++;
      if (STALL !== m_stall()) begin errors++; $display("FAIL rand_stall cyc %0d got %b want %b", i, STALL, m_stall()); end
      checks++;
      if (FWD_AV !== m_fwd(REG_IR_O_A, REG_IR_O_AV)) begin errors++; $display("FAIL rand_fwd_a cyc %0d got %h want %h", i, FWD_AV, m_fwd(REG_IR_O_A, REG_IR_O_AV)); end
      checks++;
      if (FWD_BV !== m_fwd(REG_IR_O_B, REG_IR_O_BV)) begin errors++; $display("FAIL rand_fwd_b cyc %0d got %h want %h", i, FWD_BV, m_fwd(REG_IR_O_B, REG_IR_O_BV)); end
      tick(); #1;
      checks++;
      if (ERR !== merr) begin errors++; $display("FAIL rand_err cyc %0d got %b want %b", i, ERR, merr); end
    end
    idle();
  endtask

  initial begin
    foreach (mcnt[i]) mcnt[i] = 0;
    merr = 0;
    idle();
    @(negedge CLK);
    test_reset();
    test_raw();
    test_fwd_hazard();
    test_saturate();
    test_bypass();
    test_err();
    test_flush();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
